axi_rd_arbiter: RTL and testbench

//  Round-robin arbiter: M_NUM AXI read masters share one AXI read slave (AR + R channels).
//  One burst in flight at a time; grant is held from address acceptance until the RLAST beat.

---
 rtl/axi_rd_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter letting M_NUM AXI read masters share one read slave, one burst in flight.
// Optional: define AXI_RD_ARB_ERR_RESP_EN to answer reserved-burst (2'b11) requests locally with SLVERR.
module axi_rd_arbiter #(
  parameter int unsigned M_NUM    = 2,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [M_NUM*ID_WIDTH-1:0]    M_RD_ADDR_ID,
  input  logic [M_NUM*32-1:0]          M_RD_ADDR,
  input  logic [M_NUM*8-1:0]           M_RD_ADDR_LEN,
  input  logic [M_NUM*2-1:0]           M_RD_ADDR_BURST,
  input  logic [M_NUM-1:0]             M_RD_ADDR_VALID,
  output logic [M_NUM-1:0]             M_RD_ADDR_READY,
  output logic [M_NUM*ID_WIDTH-1:0]    M_RD_BACK_ID,
  output logic [M_NUM*32-1:0]          M_RD_DATA,
  output logic [M_NUM*2-1:0]           M_RD_DATA_RESP,
  output logic [M_NUM-1:0]             M_RD_DATA_LAST,
  output logic [M_NUM-1:0]             M_RD_DATA_VALID,
  input  logic [M_NUM-1:0]             M_RD_DATA_READY,
  output logic [ID_WIDTH-1:0]          S_RD_ADDR_ID,
  output logic [31:0]                  S_RD_ADDR,
  output logic [7:0]                   S_RD_ADDR_LEN,
  output logic [1:0]                   S_RD_ADDR_BURST,
  output logic                         S_RD_ADDR_VALID,
  input  logic                         S_RD_ADDR_READY,
  input  logic [ID_WIDTH-1:0]          S_RD_BACK_ID,
  input  logic [31:0]                  S_RD_DATA,
  input  logic [1:0]                   S_RD_DATA_RESP,
  input  logic                         S_RD_DATA_LAST,
  input  logic                         S_RD_DATA_VALID,
  output logic                         S_RD_DATA_READY
);

  localparam int unsigned GW = (M_NUM > 1) ? $clog2(M_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
`ifdef AXI_RD_ARB_ERR_RESP_EN
    ,
    S_ERR,
    S_ERR_DATA
`endif
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [GW-1:0] r_grant, w_nxt_grant;
  logic [GW-1:0] r_last_grant, w_nxt_last;
  logic          w_found;
  logic [GW-1:0] w_pick;

`ifdef AXI_RD_ARB_ERR_RESP_EN
  logic [7:0]          r_cnt, w_nxt_cnt;
  logic [7:0]          r_err_len, w_nxt_err_len;
  logic [ID_WIDTH-1:0] r_err_id, w_nxt_err_id;
  logic [1:0]          w_pick_burst;
`endif

  // Round-robin pick: first valid master scanning upward from the one after last_grant.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
`ifdef AXI_RD_ARB_ERR_RESP_EN
    w_pick_burst = '0;
`endif
    for (int i = 1; i <= int'(M_NUM); i++) begin
      for (int k = 0; k < int'(M_NUM); k++) begin
        if (!w_found && M_RD_ADDR_VALID[k] && (k == (int'(r_last_grant) + i) % int'(M_NUM))) begin
          w_found = 1'b1;
          w_pick  = GW'(k);
`ifdef AXI_RD_ARB_ERR_RESP_EN
          w_pick_burst = M_RD_ADDR_BURST[k*2 +: 2];
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(M_NUM - 1);
`ifdef AXI_RD_ARB_ERR_RESP_EN
      r_cnt        <= '0;
      r_err_len    <= '0;
      r_err_id     <= '0;
`endif
    end else begin
      r_state      <= w_nxt_state;
      r_grant      <= w_nxt_grant;
      r_last_grant <= w_nxt_last;
`ifdef AXI_RD_ARB_ERR_RESP_EN
      r_cnt        <= w_nxt_cnt;
      r_err_len    <= w_nxt_err_len;
      r_err_id     <= w_nxt_err_id;
`endif
    end
  end

  // Next state plus the grant-steered AR/R muxes; everything idles at zero.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_grant     = r_grant;
    w_nxt_last      = r_last_grant;
    M_RD_ADDR_READY = '0;
    M_RD_BACK_ID    = '0;
    M_RD_DATA       = '0;
    M_RD_DATA_RESP  = '0;
    M_RD_DATA_LAST  = '0;
    M_RD_DATA_VALID = '0;
    S_RD_ADDR_ID    = '0;
    S_RD_ADDR       = '0;
    S_RD_ADDR_LEN   = '0;
    S_RD_ADDR_BURST = '0;
    S_RD_ADDR_VALID = 1'b0;
    S_RD_DATA_READY = 1'b0;
`ifdef AXI_RD_ARB_ERR_RESP_EN
    w_nxt_cnt     = r_cnt;
    w_nxt_err_len = r_err_len;
    w_nxt_err_id  = r_err_id;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_grant = w_pick;
`ifdef AXI_RD_ARB_ERR_RESP_EN
          w_nxt_state = (w_pick_burst == 2'b11) ? S_ERR : S_ADDR;
`else
          w_nxt_state = S_ADDR;
`endif
        end
      end
      S_ADDR: begin
        S_RD_ADDR_VALID = 1'b1;
        for (int k = 0; k < int'(M_NUM); k++) begin
          if (GW'(k) == r_grant) begin
            S_RD_ADDR_ID       = M_RD_ADDR_ID[k*ID_WIDTH +: ID_WIDTH];
            S_RD_ADDR          = M_RD_ADDR[k*32 +: 32];
            S_RD_ADDR_LEN      = M_RD_ADDR_LEN[k*8 +: 8];
            S_RD_ADDR_BURST    = M_RD_ADDR_BURST[k*2 +: 2];
            M_RD_ADDR_READY[k] = S_RD_ADDR_READY;
          end
        end
        if (S_RD_ADDR_READY) w_nxt_state = S_DATA;
      end
      S_DATA: begin
        for (int k = 0; k < int'(M_NUM); k++) begin
          if (GW'(k) == r_grant) begin
            M_RD_BACK_ID[k*ID_WIDTH +: ID_WIDTH] = S_RD_BACK_ID;
            M_RD_DATA[k*32 +: 32]                = S_RD_DATA;
            M_RD_DATA_RESP[k*2 +: 2]             = S_RD_DATA_RESP;
            M_RD_DATA_LAST[k]                    = S_RD_DATA_LAST;
            M_RD_DATA_VALID[k]                   = S_RD_DATA_VALID;
            S_RD_DATA_READY                      = M_RD_DATA_READY[k];
          end
        end
        // Only LAST closes the burst; beats are never counted here.
        if (S_RD_DATA_VALID && S_RD_DATA_READY && S_RD_DATA_LAST) begin
          w_nxt_state = S_IDLE;
          w_nxt_last  = r_grant;
        end
      end
`ifdef AXI_RD_ARB_ERR_RESP_EN
      S_ERR: begin
        for (int k = 0; k < int'(M_NUM); k++) begin
          if (GW'(k) == r_grant) begin
            M_RD_ADDR_READY[k] = 1'b1;
            w_nxt_err_id       = M_RD_ADDR_ID[k*ID_WIDTH +: ID_WIDTH];
            w_nxt_err_len      = M_RD_ADDR_LEN[k*8 +: 8];
          end
        end
        w_nxt_cnt   = '0;
        w_nxt_state = S_ERR_DATA;
      end
      S_ERR_DATA: begin
        for (int k = 0; k < int'(M_NUM); k++) begin
          if (GW'(k) == r_grant) begin
            M_RD_BACK_ID[k*ID_WIDTH +: ID_WIDTH] = r_err_id;
            M_RD_DATA_RESP[k*2 +: 2]             = 2'b10;
            M_RD_DATA_LAST[k]                    = (r_cnt == r_err_len);
            M_RD_DATA_VALID[k]                   = 1'b1;
            if (M_RD_DATA_READY[k]) begin
              w_nxt_cnt = r_cnt + 8'd1;
              if (r_cnt == r_err_len) begin
                w_nxt_state = S_IDLE;
                w_nxt_last  = r_grant;
              end
            end
          end
        end
      end
`endif
      default: w_nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_axi_rd_arbiter;

  localparam int MN = 2;
  localparam int IW = 2;
  localparam int MAX_CYC = 20000;

  logic              CLK;
  logic              RST;
  logic [MN*IW-1:0]  M_RD_ADDR_ID;
  logic [MN*32-1:0]  M_RD_ADDR;
  logic [MN*8-1:0]   M_RD_ADDR_LEN;
  logic [MN*2-1:0]   M_RD_ADDR_BURST;
  logic [MN-1:0]     M_RD_ADDR_VALID;
  logic [MN-1:0]     M_RD_ADDR_READY;
  logic [MN*IW-1:0]  M_RD_BACK_ID;
  logic [MN*32-1:0]  M_RD_DATA;
  logic [MN*2-1:0]   M_RD_DATA_RESP;
  logic [MN-1:0]     M_RD_DATA_LAST;
  logic [MN-1:0]     M_RD_DATA_VALID;
  logic [MN-1:0]     M_RD_DATA_READY;
  logic [IW-1:0]     S_RD_ADDR_ID;
  logic [31:0]       S_RD_ADDR;
  logic [7:0]        S_RD_ADDR_LEN;
  logic [1:0]        S_RD_ADDR_BURST;
  logic              S_RD_ADDR_VALID;
  logic              S_RD_ADDR_READY;
  logic [IW-1:0]     S_RD_BACK_ID;
  logic [31:0]       S_RD_DATA;
  logic [1:0]        S_RD_DATA_RESP;
  logic              S_RD_DATA_LAST;
  logic              S_RD_DATA_VALID;
  logic              S_RD_DATA_READY;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0]   addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    logic [1:0]    burst;
  } areq_t;

  typedef struct {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  areq_t mq[MN][$];
  beat_t eq[MN][$];
  areq_t sq[$];
  int    sbeat;
  int    rr_last;

  axi_rd_arbiter #(.M_NUM(MN), .ID_WIDTH(IW)) dut (
    .CLK(CLK), .RST(RST),
    .M_RD_ADDR_ID(M_RD_ADDR_ID), .M_RD_ADDR(M_RD_ADDR), .M_RD_ADDR_LEN(M_RD_ADDR_LEN),
    .M_RD_ADDR_BURST(M_RD_ADDR_BURST), .M_RD_ADDR_VALID(M_RD_ADDR_VALID),
    .M_RD_ADDR_READY(M_RD_ADDR_READY), .M_RD_BACK_ID(M_RD_BACK_ID), .M_RD_DATA(M_RD_DATA),
    .M_RD_DATA_RESP(M_RD_DATA_RESP), .M_RD_DATA_LAST(M_RD_DATA_LAST),
    .M_RD_DATA_VALID(M_RD_DATA_VALID), .M_RD_DATA_READY(M_RD_DATA_READY),
    .S_RD_ADDR_ID(S_RD_ADDR_ID), .S_RD_ADDR(S_RD_ADDR), .S_RD_ADDR_LEN(S_RD_ADDR_LEN),
    .S_RD_ADDR_BURST(S_RD_ADDR_BURST), .S_RD_ADDR_VALID(S_RD_ADDR_VALID),
    .S_RD_ADDR_READY(S_RD_ADDR_READY), .S_RD_BACK_ID(S_RD_BACK_ID), .S_RD_DATA(S_RD_DATA),
    .S_RD_DATA_RESP(S_RD_DATA_RESP), .S_RD_DATA_LAST(S_RD_DATA_LAST),
    .S_RD_DATA_VALID(S_RD_DATA_VALID), .S_RD_DATA_READY(S_RD_DATA_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [1:0] beat_resp(input logic [31:0] a, input int b);
    return 2'(b) ^ a[3:2];
  endfunction

  function automatic bit traffic_pending();
    bit p = (sq.size() != 0);
    for (int k = 0; k < MN; k++) if (mq[k].size() != 0 || eq[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    M_RD_ADDR_ID = '0; M_RD_ADDR = '0; M_RD_ADDR_LEN = '0; M_RD_ADDR_BURST = '0;
    M_RD_ADDR_VALID = '0; M_RD_DATA_READY = '0;
    S_RD_ADDR_READY = 1'b0; S_RD_BACK_ID = '0; S_RD_DATA = '0; S_RD_DATA_RESP = '0;
    S_RD_DATA_LAST = 1'b0; S_RD_DATA_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    M_RD_ADDR_VALID = '1;
    S_RD_DATA_VALID = 1'b1;
    S_RD_ADDR_READY = 1'b1;
    tick();
    tick();
    @(negedge CLK);
    vectors++;
    if ({S_RD_ADDR_VALID, M_RD_ADDR_READY, M_RD_DATA_VALID, S_RD_DATA_READY} !== '0) begin
      miscompares++;
      $display("FAIL reset_handshakes: got %b expected 0",
               {S_RD_ADDR_VALID, M_RD_ADDR_READY, M_RD_DATA_VALID, S_RD_DATA_READY});
    end
    vectors++;
    if ({M_RD_DATA, S_RD_ADDR} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got %h expected 0", {M_RD_DATA, S_RD_ADDR});
    end
    tick();
    RST = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_burst();
    do_reset();
    M_RD_ADDR_VALID = 2'b01; M_RD_ADDR[31:0] = 32'h100; M_RD_ADDR_LEN[7:0] = 8'd3;
    M_RD_ADDR_ID[1:0] = 2'd1; M_RD_ADDR_BURST[1:0] = 2'b01;
    @(negedge CLK);
    vectors++;
    if (S_RD_ADDR_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle_cycle: got S_AR_VALID=%b expected 0", S_RD_ADDR_VALID);
    end
    tick();
    S_RD_DATA_VALID = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({S_RD_ADDR_VALID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_ID, S_RD_ADDR_BURST,
         M_RD_ADDR_READY, S_RD_DATA_READY} !== {1'b1, 32'h100, 8'd3, 2'd1, 2'b01, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL single_ar_fwd: got v=%b a=%h l=%0d id=%0d b=%b rdy=%b srr=%b",
               S_RD_ADDR_VALID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_ID, S_RD_ADDR_BURST,
               M_RD_ADDR_READY, S_RD_DATA_READY);
    end
    tick();
    S_RD_ADDR_READY = 1'b1;
    @(negedge CLK);
    vectors++;
    if (M_RD_ADDR_READY !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ar_ready: got %b expected 01", M_RD_ADDR_READY);
    end
    tick();
    M_RD_ADDR_VALID = '0; S_RD_ADDR_READY = 1'b0; M_RD_DATA_READY = 2'b11;
    for (int b = 0; b < 4; b++) begin
      S_RD_DATA_VALID = 1'b1; S_RD_DATA = beat_data(32'h100, b); S_RD_BACK_ID = 2'd1;
      S_RD_DATA_RESP = 2'b00; S_RD_DATA_LAST = (b == 3);
      @(negedge CLK);
      vectors++;
      if ({M_RD_DATA_VALID, M_RD_DATA_LAST, M_RD_DATA, M_RD_BACK_ID, S_RD_DATA_READY} !==
          {2'b01, 1'b0, (b == 3), 32'd0, beat_data(32'h100, b), 2'd0, 2'd1, 1'b1}) begin
        miscompares++;
        $display("FAIL single_beat%0d: got v=%b l=%b d=%h id=%h srr=%b expected data %h",
                 b, M_RD_DATA_VALID, M_RD_DATA_LAST, M_RD_DATA, M_RD_BACK_ID, S_RD_DATA_READY,
                 beat_data(32'h100, b));
      end
      tick();
    end
    S_RD_DATA_LAST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({S_RD_DATA_READY, M_RD_DATA_VALID, S_RD_ADDR_VALID} !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_back_to_idle: got %b expected 0000",
               {S_RD_DATA_READY, M_RD_DATA_VALID, S_RD_ADDR_VALID});
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    M_RD_ADDR_VALID = 2'b10; M_RD_ADDR[63:32] = 32'h200; M_RD_ADDR_LEN[15:8] = 8'd3;
    M_RD_ADDR_ID[3:2] = 2'd2; S_RD_ADDR_READY = 1'b1;
    tick();
    @(negedge CLK);
    vectors++;
    if (M_RD_ADDR_READY !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_ar_ready: got %b expected 10", M_RD_ADDR_READY);
    end
    tick();
    clear_inputs();
    M_RD_DATA_READY = 2'b11;
    for (int b = 0; b < 4; b++) begin
      S_RD_DATA_VALID = 1'b1; S_RD_DATA = beat_data(32'h200, b); S_RD_BACK_ID = 2'd2;
      S_RD_DATA_LAST = (b == 3);
      if (b == 1) begin
        M_RD_DATA_READY = 2'b01;
        for (int s = 0; s < 5; s++) begin
          @(negedge CLK);
          vectors++;
          if ({S_RD_DATA_READY, M_RD_DATA_VALID, M_RD_DATA[63:32]} !== {1'b0, 2'b10, beat_data(32'h200, 1)}) begin
            miscompares++;
            $display("FAIL bp_stall%0d: got srr=%b v=%b d=%h expected srr=0 v=10", s,
                     S_RD_DATA_READY, M_RD_DATA_VALID, M_RD_DATA[63:32]);
          end
          tick();
        end
        M_RD_DATA_READY = 2'b11;
      end
      @(negedge CLK);
      vectors++;
      if ({S_RD_DATA_READY, M_RD_DATA_VALID, M_RD_DATA_LAST, M_RD_DATA[63:32]} !==
          {1'b1, 2'b10, (b == 3), 1'b0, beat_data(32'h200, b)}) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got srr=%b v=%b l=%b d=%h expected d=%h", b, S_RD_DATA_READY,
                 M_RD_DATA_VALID, M_RD_DATA_LAST, M_RD_DATA[63:32], beat_data(32'h200, b));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    M_RD_ADDR_VALID = 2'b01; M_RD_ADDR[31:0] = 32'h300; M_RD_ADDR_LEN[7:0] = 8'd7;
    S_RD_ADDR_READY = 1'b1;
    tick();
    tick();
    clear_inputs();
    M_RD_DATA_READY = 2'b11;
    for (int b = 0; b < 3; b++) begin
      S_RD_DATA_VALID = 1'b1; S_RD_DATA = beat_data(32'h300, b);
      if (b == 2) RST = 1'b1;
      tick();
    end
    @(negedge CLK);
    vectors++;
    if ({S_RD_ADDR_VALID, M_RD_ADDR_READY, M_RD_DATA_VALID, M_RD_DATA_LAST, S_RD_DATA_READY,
         M_RD_DATA} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got v=%b srr=%b d=%h expected all 0", M_RD_DATA_VALID,
               S_RD_DATA_READY, M_RD_DATA);
    end
    tick();
    RST = 1'b0;
    S_RD_DATA_VALID = 1'b0;
    M_RD_ADDR_VALID = 2'b11; M_RD_ADDR = {32'h4444_0000, 32'h3333_0000}; S_RD_ADDR_READY = 1'b1;
    tick();
    @(negedge CLK);
    vectors++;
    if ({M_RD_ADDR_READY, S_RD_ADDR} !== {2'b01, 32'h3333_0000}) begin
      miscompares++;
      $display("FAIL rstmid_m0_wins: got rdy=%b a=%h expected 01 33330000", M_RD_ADDR_READY, S_RD_ADDR);
    end
    clear_inputs();
  endtask

`ifdef AXI_RD_ARB_ERR_RESP_EN
  task automatic test_err_resp();
    do_reset();
    M_RD_ADDR_VALID = 2'b10; M_RD_ADDR[63:32] = $urandom; M_RD_ADDR_LEN[15:8] = 8'd2;
    M_RD_ADDR_ID[3:2] = 2'd3; M_RD_ADDR_BURST[3:2] = 2'b11; S_RD_ADDR_READY = 1'b1;
    tick();
    @(negedge CLK);
    vectors++;
    if ({M_RD_ADDR_READY, S_RD_ADDR_VALID} !== {2'b10, 1'b0}) begin
      miscompares++;
      $display("FAIL err_accept: got rdy=%b sv=%b expected 10 0", M_RD_ADDR_READY, S_RD_ADDR_VALID);
    end
    tick();
    M_RD_ADDR_VALID = '0;
    M_RD_DATA_READY = 2'b11;
    for (int b = 0; b < 3; b++) begin
      if (b == 1) begin
        M_RD_DATA_READY = 2'b01;
        tick();
        M_RD_DATA_READY = 2'b11;
      end
      @(negedge CLK);
      vectors++;
      if ({M_RD_DATA_VALID, M_RD_DATA_LAST, M_RD_DATA, M_RD_DATA_RESP, M_RD_BACK_ID, S_RD_ADDR_VALID} !==
          {2'b10, (b == 2), 1'b0, 64'd0, 2'b10, 2'b00, 2'd3, 2'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL err_beat%0d: got v=%b l=%b d=%h r=%b id=%h sv=%b", b, M_RD_DATA_VALID,
                 M_RD_DATA_LAST, M_RD_DATA, M_RD_DATA_RESP, M_RD_BACK_ID, S_RD_ADDR_VALID);
      end
      tick();
    end
    @(negedge CLK);
    vectors++;
    if (M_RD_DATA_VALID !== 2'b00) begin
      miscompares++;
      $display("FAIL err_done: got v=%b expected 00", M_RD_DATA_VALID);
    end
    clear_inputs();
  endtask
`endif

  // Traffic engine: masters queue requests, a slave model answers, a scoreboard checks routing and order.
  task automatic run_traffic(input int nreq, input bit rnd);
    areq_t r;
    beat_t eb;
    int    cyc, exp_g, mhs, shs;
    do_reset();
    sq.delete();
    sbeat = 0;
    rr_last = MN - 1;
    for (int k = 0; k < MN; k++) begin
      mq[k].delete();
      eq[k].delete();
      for (int n = 0; n < nreq; n++) begin
        r.addr = $urandom;
        r.len = 8'($urandom_range(0, rnd ? 15 : 3));
        r.id = IW'($urandom);
`ifdef AXI_RD_ARB_ERR_RESP_EN
        r.burst = 2'($urandom_range(0, 2));
`else
        r.burst = 2'($urandom_range(0, 3));
`endif
        mq[k].push_back(r);
      end
    end
    cyc = 0;
    while (traffic_pending() && cyc < MAX_CYC) begin
      for (int k = 0; k < MN; k++) begin
        M_RD_ADDR_VALID[k] = (mq[k].size() != 0);
        if (mq[k].size() != 0) begin
          M_RD_ADDR[k*32 +: 32] = mq[k][0].addr;
          M_RD_ADDR_LEN[k*8 +: 8] = mq[k][0].len;
          M_RD_ADDR_ID[k*IW +: IW] = mq[k][0].id;
          M_RD_ADDR_BURST[k*2 +: 2] = mq[k][0].burst;
        end
        M_RD_DATA_READY[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      S_RD_ADDR_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sq.size() != 0) begin
        S_RD_DATA_VALID = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        S_RD_DATA = beat_data(sq[0].addr, sbeat);
        S_RD_BACK_ID = sq[0].id;
        S_RD_DATA_RESP = beat_resp(sq[0].addr, sbeat);
        S_RD_DATA_LAST = (sbeat == int'(sq[0].len));
      end else begin
        S_RD_DATA_VALID = 1'b0;
      end
      @(negedge CLK);
      vectors++;
      if (sq.size() != 0 && M_RD_ADDR_READY != '0) begin
        miscompares++;
        $display("FAIL ar_ready_while_busy: got %b expected 0 at cycle %0d", M_RD_ADDR_READY, cyc);
      end
      mhs = 0;
      for (int k = 0; k < MN; k++) begin
        if (M_RD_ADDR_VALID[k] && M_RD_ADDR_READY[k]) begin
          exp_g = -1;
          for (int i = 1; i <= MN; i++)
            if (exp_g < 0 && mq[(rr_last + i) % MN].size() != 0) exp_g = (rr_last + i) % MN;
          vectors++;
          if (k != exp_g) begin
            miscompares++;
            $display("FAIL grant_order: got master %0d expected %0d", k, exp_g);
          end
          r = mq[k].pop_front();
          vectors++;
          if ({S_RD_ADDR_VALID, S_RD_ADDR_READY, S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST} !==
              {2'b11, r.id, r.addr, r.len, r.burst}) begin
            miscompares++;
            $display("FAIL ar_payload: got a=%h l=%0d id=%0d b=%b expected a=%h l=%0d id=%0d b=%b",
                     S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_ID, S_RD_ADDR_BURST, r.addr, r.len, r.id, r.burst);
          end
          sq.push_back(r);
          for (int b = 0; b <= int'(r.len); b++) begin
            eb.data = beat_data(r.addr, b);
            eb.id = r.id;
            eb.resp = beat_resp(r.addr, b);
            eb.last = (b == int'(r.len));
            eq[k].push_back(eb);
          end
          rr_last = k;
          mhs++;
        end
      end
      vectors++;
      if ((S_RD_ADDR_VALID && S_RD_ADDR_READY) != (mhs == 1)) begin
        miscompares++;
        $display("FAIL ar_handshake_pairing: got slave hs=%b master hs=%0d", S_RD_ADDR_VALID && S_RD_ADDR_READY, mhs);
      end
      mhs = 0;
      for (int k = 0; k < MN; k++) begin
        if (M_RD_DATA_VALID[k] && M_RD_DATA_READY[k]) begin
          mhs++;
          vectors++;
          if (eq[k].size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: got beat on master %0d expected none", k);
          end else begin
            eb = eq[k].pop_front();
            if ({M_RD_DATA[k*32 +: 32], M_RD_BACK_ID[k*IW +: IW], M_RD_DATA_RESP[k*2 +: 2], M_RD_DATA_LAST[k]} !==
                {eb.data, eb.id, eb.resp, eb.last}) begin
              miscompares++;
              $display("FAIL r_beat m%0d: got d=%h id=%0d r=%b l=%b expected d=%h id=%0d r=%b l=%b", k,
                       M_RD_DATA[k*32 +: 32], M_RD_BACK_ID[k*IW +: IW], M_RD_DATA_RESP[k*2 +: 2],
                       M_RD_DATA_LAST[k], eb.data, eb.id, eb.resp, eb.last);
            end
          end
        end
      end
      shs = (S_RD_DATA_VALID && S_RD_DATA_READY) ? 1 : 0;
      if (shs == 1) begin
        if (sbeat == int'(sq[0].len)) begin
          void'(sq.pop_front());
          sbeat = 0;
        end else begin
          sbeat++;
        end
      end
      vectors++;
      if (mhs != shs) begin
        miscompares++;
        $display("FAIL r_handshake_pairing: got master hs=%0d expected %0d", mhs, shs);
      end
      tick();
      cyc++;
    end
    vectors++;
    if (cyc >= MAX_CYC) begin
      miscompares++;
      $display("FAIL traffic_timeout: got %0d cycles expected under %0d", cyc, MAX_CYC);
    end
    clear_inputs();
  endtask

  task automatic test_fairness();
    run_traffic(3, 1'b0);
  endtask

  task automatic test_random();
    run_traffic(25, 1'b1);
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_backpressure();
    test_fairness();
    test_reset_mid_burst();
`ifdef AXI_RD_ARB_ERR_RESP_EN
    test_err_resp();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
